// File: rtl/sev_seg_scan.sv
// sev_seg_scan
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
//
// Features: full hex decode, per-digit decimal point and blank,
// leading-zero suppression, an anti-ghost guard interval at the start
// of every digit slot, PWM brightness, and double-buffered loading so
// that a new value never shows up part-way through a frame.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   digit_data   4*NUM_DIGITS, nibble i = value of digit i
//   digit_blank  NUM_DIGITS, 1 = digit i dark
//   dp_in        NUM_DIGITS, 1 = decimal point i lit
//   load         1-cycle strobe capturing digit_data/digit_blank/dp_in
//   lz_suppress  1 = blank leading zeros
//   brightness   BRIGHT_W, 0 = off, all ones = full on
//   IO_SSEG_SEL  anode selects, active low
//   IO_SSEG      segments gfedcba (bit0 = a), active low
//   IO_SSEG_DP   decimal point, active low
//   frame_done   1-cycle pulse marking the start of a new frame on the pins
module sev_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_TICKS = 100000,
    parameter int GUARD_TICKS = 1000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   digit_blank,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   IO_SSEG_SEL,
    output logic [6:0]              IO_SSEG,
    output logic                    IO_SSEG_DP,
    output logic                    frame_done
);

    localparam int TICK_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    logic [TICK_W-1:0]       tick;
    logic [IDX_W-1:0]        idx;
    logic [BRIGHT_W-1:0]     pwm;
    logic [BRIGHT_W-1:0]     bright_s;

    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_valid;

    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_blank;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    lz_s;

    logic                    wrapped;

    logic                    tick_last;
    logic                    idx_last;
    logic                    boundary;
    logic                    in_guard;
    logic                    pwm_on;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   visible;
    logic                    lz_run;
    logic [3:0]              cur_nib;
    logic                    cur_vis;
    logic                    cur_dp;
    logic [6:0]              seg_dec;
    logic [NUM_DIGITS-1:0]   sel_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    assign tick_last = (tick == TICK_W'(DIGIT_TICKS - 1));
    assign idx_last  = (idx == IDX_W'(NUM_DIGITS - 1));
    assign boundary  = tick_last && idx_last;
    assign in_guard  = (tick < TICK_W'(GUARD_TICKS));

    // An all-ones level bypasses the comparison so full brightness
    // really is 100% duty rather than (2^W-1)/2^W.
    assign pwm_on = (bright_s == '1) || (pwm < bright_s);

    // Leading-zero mask: walk down from the top digit while the value is
    // zero; the first nonzero digit stops the run. Digit 0 is never blanked.
    always_comb begin
        lz_blank = '0;
        lz_run   = lz_s;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lz_run && (disp_data[i*4 +: 4] == 4'h0)) begin
                lz_blank[i] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
    end

    assign visible = ~disp_blank & ~lz_blank;

    // Select the current digit's nibble, visibility and DP, and decide
    // which anode (if any) is driven this cycle.
    always_comb begin
        cur_nib  = 4'h0;
        cur_vis  = 1'b0;
        cur_dp   = 1'b0;
        sel_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib = disp_data[i*4 +: 4];
                cur_vis = visible[i];
                cur_dp  = disp_dp[i];
                if (!in_guard && visible[i] && pwm_on) begin
                    sel_next[i] = 1'b0;
                end
            end
        end
    end

    // Active-low hex decode, gfedcba.
    always_comb begin
        case (cur_nib)
            4'h0:    seg_dec = 7'h40;
            4'h1:    seg_dec = 7'h79;
            4'h2:    seg_dec = 7'h24;
            4'h3:    seg_dec = 7'h30;
            4'h4:    seg_dec = 7'h19;
            4'h5:    seg_dec = 7'h12;
            4'h6:    seg_dec = 7'h02;
            4'h7:    seg_dec = 7'h78;
            4'h8:    seg_dec = 7'h00;
            4'h9:    seg_dec = 7'h10;
            4'hA:    seg_dec = 7'h08;
            4'hB:    seg_dec = 7'h03;
            4'hC:    seg_dec = 7'h46;
            4'hD:    seg_dec = 7'h21;
            4'hE:    seg_dec = 7'h06;
            default: seg_dec = 7'h0E;
        endcase
    end

    assign seg_next = cur_vis ? seg_dec : 7'h7F;
    assign dp_next  = cur_vis ? ~cur_dp : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick        <= '0;
            idx         <= '0;
            pwm         <= '0;
            bright_s    <= '0;
            pend_data   <= '0;
            pend_blank  <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            disp_data   <= '0;
            disp_blank  <= '1;
            disp_dp     <= '0;
            lz_s        <= 1'b0;
            wrapped     <= 1'b0;
            frame_done  <= 1'b0;
            IO_SSEG_SEL <= '1;
            IO_SSEG     <= 7'h7F;
            IO_SSEG_DP  <= 1'b1;
        end else begin
            tick <= tick_last ? '0 : tick + 1'b1;
            if (tick_last) begin
                idx <= idx_last ? '0 : idx + 1'b1;
            end
            pwm <= pwm + 1'b1;

            // Brightness is held for the whole slot; the new value is
            // first used in the guard, where the anodes are off anyway.
            if (tick == '0) begin
                bright_s <= brightness;
            end

            if (load) begin
                pend_data  <= digit_data;
                pend_blank <= digit_blank;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end

            // Frame boundary: swap in the pending image. A load arriving in
            // this very cycle is forwarded straight to the display so it is
            // not delayed a whole frame.
            if (boundary) begin
                pend_valid <= 1'b0;
                lz_s       <= lz_suppress;
                if (load) begin
                    disp_data  <= digit_data;
                    disp_blank <= digit_blank;
                    disp_dp    <= dp_in;
                end else if (pend_valid) begin
                    disp_data  <= pend_data;
                    disp_blank <= pend_blank;
                    disp_dp    <= pend_dp;
                end
            end

            // Delayed one extra stage so the pulse lines up with the pins
            // showing the digit-0 guard of the new frame.
            wrapped     <= boundary;
            frame_done  <= wrapped;
            IO_SSEG_SEL <= sel_next;
            IO_SSEG     <= seg_next;
            IO_SSEG_DP  <= dp_next;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan.sv
// tb_sev_seg_scan
// Directed self-checking bench for sev_seg_scan using small simulation
// parameters (4 digits, 16 ticks per slot, 2 guard ticks, 2-bit PWM).
// Each frame is 64 cycles; pin sample index c within a frame maps to
// digit c/16, tick c%16, with c=0 being the cycle frame_done is high.
module tb_sev_seg_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] digit_data;
    logic [3:0]  digit_blank;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_suppress;
    logic [1:0]  brightness;
    logic [3:0]  IO_SSEG_SEL;
    logic [6:0]  IO_SSEG;
    logic        IO_SSEG_DP;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    sev_seg_scan #(
        .NUM_DIGITS  (4),
        .DIGIT_TICKS (16),
        .GUARD_TICKS (2),
        .BRIGHT_W    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_data  (digit_data),
        .digit_blank (digit_blank),
        .dp_in       (dp_in),
        .load        (load),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .IO_SSEG_SEL (IO_SSEG_SEL),
        .IO_SSEG     (IO_SSEG),
        .IO_SSEG_DP  (IO_SSEG_DP),
        .frame_done  (frame_done)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any failure.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next frame_done pulse; returns on that negedge.
    task automatic wait_frame();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = frame_done;
        end
        check_output("frame_wait", {31'd0, seen}, 32'd1);
    endtask

    // Drive a new image and pulse load, then let it reach the display.
    task automatic apply_stimulus(input logic [15:0] data, input logic [3:0] blank,
                                  input logic [3:0] dp, input logic lz, input logic [1:0] bright);
        digit_data  = data;
        digit_blank = blank;
        dp_in       = dp;
        lz_suppress = lz;
        brightness  = bright;
        load        = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (70) @(negedge clk);
        wait_frame();
    endtask

    // Observe one full frame starting on the frame_done negedge.
    // exp_seg packs digit d at [d*7 +: 7]; exp_dp is the active-low DP pin.
    task automatic scan_frame(input string name, input logic [27:0] exp_seg, input logic [3:0] exp_dp,
                              input logic [3:0] exp_vis, input int exp_low);
        int         low_cnt [4];
        logic [3:0] sel_seen [4];
        logic [6:0] seg_seen [4];
        logic       dp_seen [4];
        int         bad_sel;
        int         fd_extra;
        int         d;
        int         t;
        int         want_low;
        logic [3:0] want_sel;
        bad_sel  = 0;
        fd_extra = 0;
        for (int k = 0; k < 4; k++) begin
            low_cnt[k]  = 0;
            sel_seen[k] = 4'hF;
            seg_seen[k] = 7'h00;
            dp_seen[k]  = 1'b0;
        end
        for (int c = 0; c < 64; c++) begin
            if (c != 0) @(negedge clk);
            d = c / 16;
            t = c % 16;
            want_sel = ~(4'b0001 << d);
            if (IO_SSEG_SEL != 4'hF) begin
                low_cnt[d]++;
                sel_seen[d] = IO_SSEG_SEL;
                if (t < 2 || IO_SSEG_SEL != want_sel) bad_sel++;
            end
            if (t == 8) begin
                seg_seen[d] = IO_SSEG;
                dp_seen[d]  = IO_SSEG_DP;
            end
            if (c != 0 && frame_done) fd_extra++;
        end
        for (int k = 0; k < 4; k++) begin
            want_low = exp_vis[k] ? exp_low : 0;
            check_output($sformatf("%s_low_d%0d", name, k), low_cnt[k], want_low);
            check_output($sformatf("%s_seg_d%0d", name, k), {25'd0, seg_seen[k]}, {25'd0, exp_seg[k*7 +: 7]});
            check_output($sformatf("%s_dp_d%0d", name, k), {31'd0, dp_seen[k]}, {31'd0, exp_dp[k]});
            if (want_low > 0) begin
                check_output($sformatf("%s_sel_d%0d", name, k), {28'd0, sel_seen[k]}, {28'd0, ~(4'b0001 << k)});
            end
        end
        check_output($sformatf("%s_sel_guard", name), bad_sel, 0);
        check_output($sformatf("%s_fd_extra", name), fd_extra, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        digit_data  = 16'h0000;
        digit_blank = 4'h0;
        dp_in       = 4'h0;
        load        = 1'b0;
        lz_suppress = 1'b0;
        brightness  = 2'd0;

        // Reset values
        repeat (3) @(negedge clk);
        check_output("rst_sel", {28'd0, IO_SSEG_SEL}, 32'hF);
        check_output("rst_seg", {25'd0, IO_SSEG}, 32'h7F);
        check_output("rst_dp", {31'd0, IO_SSEG_DP}, 32'd1);
        check_output("rst_fd", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x1234 full brightness: digit0=4 ... digit3=1
        apply_stimulus(16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd3);
        scan_frame("d1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF, 14);

        // Hex letters with decimal points on digits 0 and 2
        apply_stimulus(16'hABCD, 4'b0000, 4'b0101, 1'b0, 2'd3);
        scan_frame("dABCD", {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1010, 4'hF, 14);

        // Leading-zero suppression
        apply_stimulus(16'h0050, 4'b0000, 4'b0000, 1'b1, 2'd3);
        scan_frame("lz0050", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, 4'b0011, 14);
        apply_stimulus(16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3);
        scan_frame("lz0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 4'b0001, 14);

        // No suppression, explicit blank on digit 2 (its DP request ignored)
        apply_stimulus(16'h0F00, 4'b0100, 4'b0100, 1'b0, 2'd3);
        scan_frame("blank", {7'h40, 7'h7F, 7'h40, 7'h40}, 4'hF, 4'b1011, 14);

        // Brightness 1: ticks 4, 8, 12 only; brightness 0: never lit
        apply_stimulus(16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd1);
        scan_frame("br1", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF, 3);
        apply_stimulus(16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd0);
        scan_frame("br0", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF, 0);

        // Two loads inside one frame: old image to frame end, then the last one
        apply_stimulus(16'h5678, 4'b0000, 4'b0000, 1'b0, 2'd3);
        repeat (10) @(negedge clk);
        digit_data = 16'h1111;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        digit_data = 16'h2222;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (18) @(negedge clk);
        check_output("old_d2", {25'd0, IO_SSEG}, 32'h02);
        repeat (16) @(negedge clk);
        check_output("old_d3", {25'd0, IO_SSEG}, 32'h12);
        wait_frame();
        scan_frame("last", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 4'hF, 14);

        // Load exactly in the boundary cycle takes effect at that boundary
        wait_frame();
        repeat (62) @(negedge clk);
        digit_data = 16'h3C3C;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame();
        scan_frame("bypass", {7'h30, 7'h46, 7'h30, 7'h46}, 4'hF, 4'hF, 14);

        // Reset mid-slot with a load pending: reset values next edge, and the
        // pending image is discarded so the display stays dark.
        wait_frame();
        repeat (19) @(negedge clk);
        digit_data = 16'h7777;
        load = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_output("mid_rst_sel", {28'd0, IO_SSEG_SEL}, 32'hF);
        check_output("mid_rst_seg", {25'd0, IO_SSEG}, 32'h7F);
        check_output("mid_rst_dp", {31'd0, IO_SSEG_DP}, 32'd1);
        check_output("mid_rst_fd", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        wait_frame();
        scan_frame("post_rst", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF, 4'h0, 14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
